// File: rtl/mem_stage_mmio_pkg.sv
// Shared types and address decode for the memory stage with MMIO window.
// Decode works on 32-bit zero-extended operands so one function serves any ADDR_W <= 32.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      REG_RAM      = 2'd0,
      REG_SW       = 2'd1,
      REG_GPIO     = 2'd2,
      REG_UNMAPPED = 2'd3
   } region_t;

   localparam logic [31:0] SW_OFFSET   = 32'd0;
   localparam logic [31:0] GPIO_OFFSET = 32'd1;

   typedef struct packed {
      region_t    region;
      logic [7:0] gpio_idx;
   } decode_t;

   function automatic decode_t decode_region(
      input logic [31:0] addr,
      input logic [31:0] ram_depth,
      input logic [31:0] io_base,
      input logic [31:0] n_gpio
   );
      decode_t     d;
      logic [31:0] off;
      d.region   = REG_UNMAPPED;
      d.gpio_idx = 8'd0;
      off        = addr - io_base - GPIO_OFFSET;
      if (addr < ram_depth) begin
         d.region = REG_RAM;
      end else if (addr == (io_base + SW_OFFSET)) begin
         d.region = REG_SW;
      end else if ((addr >= (io_base + GPIO_OFFSET)) && (off < n_gpio)) begin
         d.region   = REG_GPIO;
         d.gpio_idx = 8'(off);
      end else begin
         d.region = REG_UNMAPPED;
      end
      return d;
   endfunction

endpackage

// File: rtl/mem_stage_mmio_sync_ram.sv
// Single-port data RAM with synchronous read and write; no reset so it maps to block RAM.
module sync_ram #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 1024
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [DATA_W-1:0]        o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port and registered read port; read data holds while i_re is low.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_mmio.sv
// Memory stage: one load/store per cycle to data RAM or the switch/GPIO window,
// result bundle registered for write-back, with access-fault detection and counting.
module mem_stage_mmio
   import mem_stage_pkg::*;
#(
   parameter int                DATA_W    = 24,
   parameter int                ADDR_W    = 24,
   parameter int                RAM_DEPTH = 1024,
   parameter int                REG_W     = 4,
   parameter int                N_GPIO    = 2,
   parameter int                GPIO_W    = 36,
   parameter int                SW_W      = 4,
   parameter logic [ADDR_W-1:0] IO_BASE   = 24'hFFFF00
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_in_valid,
   input  logic                     i_mem_write,
   input  logic                     i_mem_to_reg,
   input  logic                     i_reg_write,
   input  logic [1:0]               i_op_type,
   input  logic [3:0]               i_op_code,
   input  logic [ADDR_W-1:0]        i_address,
   input  logic [REG_W-1:0]         i_rc,
   input  logic [DATA_W-1:0]        i_write_data,
   input  logic [SW_W-1:0]          i_switches,
   output logic [N_GPIO*GPIO_W-1:0] o_gpio,
   output logic                     o_out_valid,
   output logic                     o_out_mem_to_reg,
   output logic                     o_out_reg_write,
   output logic [1:0]               o_out_op_type,
   output logic [3:0]               o_out_op_code,
   output logic [REG_W-1:0]         o_out_rc,
   output logic [DATA_W-1:0]        o_out_read_data,
   output logic [ADDR_W-1:0]        o_out_address,
   output logic                     o_out_fault,
   output logic [7:0]               o_fault_count
);

   localparam int RA_W = $clog2(RAM_DEPTH);

   logic              w_access;
   logic              w_store;
   logic              w_both;
   logic              w_go;
   decode_t           w_dec;
   logic              w_fault;
   logic              w_ram_we;
   logic              w_ram_load;
   logic              w_gpio_we;
   logic [DATA_W-1:0] w_rd_next;
   logic [GPIO_W-1:0] w_gpio_sel;
   logic [DATA_W-1:0] w_ram_rdata;

   logic [GPIO_W-1:0] r_gpio [N_GPIO];
   logic [SW_W-1:0]   r_sw_meta;
   logic [SW_W-1:0]   r_sw_sync;
   logic              r_valid;
   logic              r_mem_to_reg;
   logic              r_reg_write;
   logic [1:0]        r_op_type;
   logic [3:0]        r_op_code;
   logic [REG_W-1:0]  r_rc;
   logic [DATA_W-1:0] r_read_data;
   logic [ADDR_W-1:0] r_address;
   logic              r_fault;
   logic              r_ram_load;
   logic [7:0]        r_fault_count;

   assign w_access = i_in_valid & (i_mem_write | i_mem_to_reg);
   assign w_store  = w_access & i_mem_write;
   assign w_both   = i_mem_write & i_mem_to_reg;
   assign w_go     = i_en & ~i_rst;
   assign w_dec    = decode_region(32'(i_address), 32'(RAM_DEPTH), 32'(IO_BASE), 32'(N_GPIO));

   // GPIO read mux for loads
   always_comb begin
      w_gpio_sel = '0;
      for (int k = 0; k < N_GPIO; k++) begin
         w_gpio_sel = (w_dec.gpio_idx == 8'(k)) ? r_gpio[k] : w_gpio_sel;
      end
   end

   // Per-region access decode: fault, write strobes and next read data
   always_comb begin
      w_fault    = 1'b0;
      w_ram_we   = 1'b0;
      w_ram_load = 1'b0;
      w_gpio_we  = 1'b0;
      w_rd_next  = '0;
      if (w_access) begin
         case (w_dec.region)
            REG_RAM: begin
               if (w_store) begin
                  w_rd_next = i_write_data;
                  w_fault   = w_both;
                  w_ram_we  = ~w_both;
               end else begin
                  w_ram_load = 1'b1;
               end
            end
            REG_SW: begin
               if (w_store) begin
                  w_rd_next = i_write_data;
                  w_fault   = 1'b1;
               end else begin
                  w_rd_next = DATA_W'(r_sw_sync);
               end
            end
            REG_GPIO: begin
               if (w_store) begin
                  w_rd_next = i_write_data;
                  w_fault   = w_both;
                  w_gpio_we = ~w_both;
               end else begin
                  w_rd_next = DATA_W'(w_gpio_sel);
               end
            end
            REG_UNMAPPED: w_fault = 1'b1;
            default:      w_fault = 1'b1;
         endcase
      end else begin
         w_fault = 1'b0;
      end
   end

   sync_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (RAM_DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_ram_we & w_go),
      .i_re    (w_ram_load & w_go),
      .i_addr  (RA_W'(i_address)),
      .i_wdata (i_write_data),
      .o_rdata (w_ram_rdata)
   );

   // Two-flop switch synchroniser; runs regardless of stage enable
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= i_switches;
         r_sw_sync <= r_sw_meta;
      end
   end

   // GPIO output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < N_GPIO; k++) begin
            r_gpio[k] <= '0;
         end
      end else if (i_en && w_gpio_we) begin
         for (int k = 0; k < N_GPIO; k++) begin
            if (w_dec.gpio_idx == 8'(k)) begin
               r_gpio[k] <= GPIO_W'(i_write_data);
            end
         end
      end
   end

   // Result bundle for write-back; an empty slot clears every field
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid      <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_reg_write  <= 1'b0;
         r_op_type    <= 2'd0;
         r_op_code    <= 4'd0;
         r_rc         <= '0;
         r_read_data  <= '0;
         r_address    <= '0;
         r_fault      <= 1'b0;
         r_ram_load   <= 1'b0;
      end else if (i_en) begin
         r_valid      <= i_in_valid;
         r_mem_to_reg <= i_in_valid & i_mem_to_reg & ~i_mem_write;
         r_reg_write  <= i_in_valid & i_reg_write;
         r_op_type    <= i_in_valid ? i_op_type : 2'd0;
         r_op_code    <= i_in_valid ? i_op_code : 4'd0;
         r_rc         <= i_in_valid ? i_rc : '0;
         r_address    <= i_in_valid ? i_address : '0;
         r_read_data  <= w_rd_next;
         r_fault      <= w_fault;
         r_ram_load   <= w_ram_load;
      end
   end

   // Saturating fault counter, advancing with each registered fault
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fault_count <= 8'd0;
      end else if (i_en && w_fault && (r_fault_count != 8'hFF)) begin
         r_fault_count <= r_fault_count + 8'd1;
      end
   end

   for (genvar k = 0; k < N_GPIO; k++) begin : g_gpio_out
      assign o_gpio[k*GPIO_W +: GPIO_W] = r_gpio[k];
   end

   // RAM loads take their data straight from the RAM output register
   assign o_out_read_data  = r_ram_load ? w_ram_rdata : r_read_data;
   assign o_out_valid      = r_valid;
   assign o_out_mem_to_reg = r_mem_to_reg;
   assign o_out_reg_write  = r_reg_write;
   assign o_out_op_type    = r_op_type;
   assign o_out_op_code    = r_op_code;
   assign o_out_rc         = r_rc;
   assign o_out_address    = r_address;
   assign o_out_fault      = r_fault;
   assign o_fault_count    = r_fault_count;

endmodule

// File: tb/tb_mem_stage_mmio.sv
// Scoreboard bench for mem_stage_mmio: expected bundles are queued when an op is driven
// and popped when the registered result appears one cycle later.
module tb_mem_stage_mmio;

   localparam logic [23:0] IOB = 24'hFFFF00;

   logic        clk = 1'b0;
   logic        rst, en, in_valid, mem_write, mem_to_reg, reg_write;
   logic [1:0]  op_type;
   logic [3:0]  op_code;
   logic [23:0] address;
   logic [3:0]  rc;
   logic [23:0] write_data;
   logic [3:0]  switches;
   logic [71:0] gpio;
   logic        out_valid, out_mem_to_reg, out_reg_write, out_fault;
   logic [1:0]  out_op_type;
   logic [3:0]  out_op_code;
   logic [3:0]  out_rc;
   logic [23:0] out_read_data, out_address;
   logic [7:0]  fault_count;

   typedef struct packed {
      logic        valid;
      logic        m2r;
      logic        rw;
      logic        fault;
      logic [1:0]  opt;
      logic [3:0]  opc;
      logic [3:0]  rc;
      logic [23:0] rd;
      logic [23:0] addr;
   } res_t;

   res_t exp_q[$];
   res_t last_exp;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_stage_mmio dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_in_valid(in_valid),
      .i_mem_write(mem_write), .i_mem_to_reg(mem_to_reg), .i_reg_write(reg_write),
      .i_op_type(op_type), .i_op_code(op_code), .i_address(address), .i_rc(rc),
      .i_write_data(write_data), .i_switches(switches), .o_gpio(gpio),
      .o_out_valid(out_valid), .o_out_mem_to_reg(out_mem_to_reg),
      .o_out_reg_write(out_reg_write), .o_out_op_type(out_op_type),
      .o_out_op_code(out_op_code), .o_out_rc(out_rc), .o_out_read_data(out_read_data),
      .o_out_address(out_address), .o_out_fault(out_fault), .o_fault_count(fault_count)
   );

   function automatic res_t get_out();
      res_t g;
      g.valid = out_valid;      g.m2r = out_mem_to_reg; g.rw = out_reg_write;
      g.fault = out_fault;      g.opt = out_op_type;    g.opc = out_op_code;
      g.rc    = out_rc;         g.rd  = out_read_data;  g.addr = out_address;
      return g;
   endfunction

   task automatic drive(input logic mw, input logic mr, input logic rw, input logic [23:0] a,
                        input logic [23:0] wd, input logic [3:0] r, input logic [1:0] ot,
                        input logic [3:0] oc);
      in_valid = 1'b1; mem_write = mw; mem_to_reg = mr; reg_write = rw;
      address = a; write_data = wd; rc = r; op_type = ot; op_code = oc;
   endtask

   task automatic op(input logic mw, input logic mr, input logic rw, input logic [23:0] a,
                     input logic [23:0] wd, input logic [3:0] r, input logic [1:0] ot,
                     input logic [3:0] oc, input logic [23:0] exp_rd, input logic exp_f,
                     input string name);
      res_t e;
      res_t g;
      drive(mw, mr, rw, a, wd, r, ot, oc);
      e.valid = 1'b1; e.m2r = mr & ~mw; e.rw = rw; e.fault = exp_f;
      e.opt = ot; e.opc = oc; e.rc = r; e.rd = exp_rd; e.addr = a;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
      g = get_out();
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, got=%h", name, g);
      end else begin
         e = exp_q.pop_front();
         last_exp = e;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, g, e);
         end
      end
   endtask

   task automatic idle(input int n);
      res_t g;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
         address = 24'd0; write_data = 24'd0; rc = 4'd0; op_type = 2'd0; op_code = 4'd0;
         exp_q.push_back('0);
         @(posedge clk); #1;
         g = get_out();
         last_exp = exp_q.pop_front();
         total++;
         if (g !== last_exp) begin
            bad++;
            $display("FAIL idle: got=%h expected=%h", g, last_exp);
         end
      end
   endtask

   task automatic check_gpio(input logic [71:0] exp_g, input string name);
      total++;
      if (gpio !== exp_g) begin
         bad++;
         $display("FAIL %s: gpio=%h expected=%h", name, gpio, exp_g);
      end
   endtask

   task automatic check_cnt(input logic [7:0] exp_c, input string name);
      total++;
      if (fault_count !== exp_c) begin
         bad++;
         $display("FAIL %s: fault_count=%0d expected=%0d", name, fault_count, exp_c);
      end
   endtask

   task automatic test_reset();
      res_t g;
      rst = 1'b1; en = 1'b1; switches = 4'd0;
      in_valid = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
      address = 24'd0; write_data = 24'd0; rc = 4'd0; op_type = 2'd0; op_code = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      g = get_out();
      total++;
      if (g !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got=%h expected=0", g);
      end
      check_gpio(72'd0, "reset_gpio");
      check_cnt(8'd0, "reset_count");
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      op(1'b1, 1'b0, 1'b0, 24'd500, 24'd35, 4'd12, 2'd2, 4'd9, 24'd35, 1'b0, "store_500");
      op(1'b0, 1'b1, 1'b1, 24'd500, 24'd0, 4'd12, 2'd2, 4'd9, 24'd35, 1'b0, "load_500");
      op(1'b0, 1'b0, 1'b1, 24'd42, 24'd7, 4'd3, 2'd1, 4'd4, 24'd0, 1'b0, "alu_op");
      idle(1);
   endtask

   task automatic test_gpio();
      op(1'b1, 1'b0, 1'b0, IOB + 24'd1, 24'h123456, 4'd0, 2'd0, 4'd0, 24'h123456, 1'b0, "gpio0_store");
      check_gpio({36'd0, 36'h000123456}, "gpio0_value");
      op(1'b1, 1'b0, 1'b0, IOB + 24'd2, 24'd90, 4'd0, 2'd0, 4'd0, 24'd90, 1'b0, "gpio1_store");
      check_gpio({36'd90, 36'h000123456}, "gpio1_value");
      op(1'b0, 1'b1, 1'b1, IOB + 24'd2, 24'd0, 4'd5, 2'd0, 4'd1, 24'd90, 1'b0, "gpio1_load");
      op(1'b0, 1'b1, 1'b1, IOB + 24'd1, 24'd0, 4'd6, 2'd0, 4'd1, 24'h123456, 1'b0, "gpio0_load");
   endtask

   task automatic test_switches();
      switches = 4'b1101;
      idle(2);
      op(1'b0, 1'b1, 1'b1, IOB, 24'd0, 4'd1, 2'd0, 4'd0, 24'd13, 1'b0, "sw_load");
      switches = 4'b0000;
      op(1'b0, 1'b1, 1'b1, IOB, 24'd0, 4'd1, 2'd0, 4'd0, 24'd13, 1'b0, "sw_delayed");
      idle(2);
      op(1'b0, 1'b1, 1'b1, IOB, 24'd0, 4'd1, 2'd0, 4'd0, 24'd0, 1'b0, "sw_cleared");
   endtask

   task automatic test_stall();
      res_t g;
      op(1'b1, 1'b0, 1'b0, 24'd700, 24'd11, 4'd0, 2'd0, 4'd0, 24'd11, 1'b0, "store_700");
      op(1'b0, 1'b1, 1'b1, 24'd500, 24'd0, 4'd8, 2'd3, 4'd2, 24'd35, 1'b0, "pre_stall");
      en = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 24'd700, 24'd55, 4'd0, 2'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         g = get_out();
         total++;
         if (g !== last_exp) begin
            bad++;
            $display("FAIL stall_hold: got=%h expected=%h", g, last_exp);
         end
      end
      check_gpio({36'd90, 36'h000123456}, "stall_gpio");
      en = 1'b1;
      op(1'b1, 1'b0, 1'b0, 24'd700, 24'd55, 4'd0, 2'd0, 4'd0, 24'd55, 1'b0, "stall_release");
      op(1'b0, 1'b1, 1'b1, 24'd700, 24'd0, 4'd2, 2'd0, 4'd0, 24'd55, 1'b0, "load_700");
   endtask

   task automatic test_faults();
      op(1'b0, 1'b1, 1'b1, 24'h000800, 24'd0, 4'd1, 2'd0, 4'd0, 24'd0, 1'b1, "unmapped_load");
      check_cnt(8'd1, "count_1");
      op(1'b1, 1'b0, 1'b0, IOB, 24'd0, 4'd0, 2'd0, 4'd0, 24'd0, 1'b1, "sw_store");
      check_cnt(8'd2, "count_2");
      check_gpio({36'd90, 36'h000123456}, "sw_store_gpio");
      op(1'b0, 1'b1, 1'b1, IOB + 24'd3, 24'd0, 4'd1, 2'd0, 4'd0, 24'd0, 1'b1, "gpio_oob");
      check_cnt(8'd3, "count_3");
      for (int i = 0; i < 255; i++) begin
         op(1'b0, 1'b1, 1'b0, 24'h000800, 24'd0, 4'd0, 2'd0, 4'd0, 24'd0, 1'b1, "saturate");
      end
      check_cnt(8'd255, "count_saturated");
   endtask

   task automatic test_reset_store();
      res_t g;
      op(1'b1, 1'b0, 1'b0, 24'd600, 24'd66, 4'd0, 2'd0, 4'd0, 24'd66, 1'b0, "store_600");
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 24'd600, 24'd77, 4'd0, 2'd0, 4'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0; mem_write = 1'b0;
      g = get_out();
      total++;
      if (g !== '0) begin
         bad++;
         $display("FAIL rst_op_outputs: got=%h expected=0", g);
      end
      check_gpio(72'd0, "rst_op_gpio");
      check_cnt(8'd0, "rst_op_count");
      op(1'b0, 1'b1, 1'b1, 24'd600, 24'd0, 4'd4, 2'd0, 4'd0, 24'd66, 1'b0, "load_600");
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_gpio();
      test_switches();
      test_stall();
      test_faults();
      test_reset_store();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
